// File: rtl/spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master : mode-0 SPI initiator, one MSB-first frame per request.      |
// | Optional: SPI_MASTER_MISO_FALL_SAMPLE_EN samples miso on sck falls.      |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module spi_master #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [DATA_WIDTH-1:0]         req_data,
  input  logic [$clog2(DATA_WIDTH)-1:0] req_len,
  input  logic [DIV_WIDTH-1:0]          req_div,
  output logic                          rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          sck,
  output logic                          ss,
  output logic                          mosi,
  input  logic                          miso
);

  localparam int LEN_WIDTH = $clog2(DATA_WIDTH);
  localparam int CNT_WIDTH = LEN_WIDTH + 1;

`ifdef SPI_MASTER_MISO_FALL_SAMPLE_EN
  localparam bit SAMPLE_ON_FALL = 1'b1;
`else
  localparam bit SAMPLE_ON_FALL = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                state_q,     state_d;
  logic [DIV_WIDTH-1:0]  div_q,       div_d;
  logic [DIV_WIDTH-1:0]  hdiv_q,      hdiv_d;
  logic [CNT_WIDTH-1:0]  nbits_q,     nbits_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_q,        tx_d;
  logic [DATA_WIDTH-1:0] rx_q,        rx_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  sck_q,       sck_d;
  logic                  ss_q,        ss_d;
  logic                  mosi_q,      mosi_d;

  logic                  div_zero;
  logic [DATA_WIDTH-1:0] rx_shifted;

  assign div_zero   = (div_q == '0);
  assign rx_shifted = {rx_q[DATA_WIDTH-2:0], miso};

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    hdiv_d      = hdiv_q;
    nbits_d     = nbits_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    sck_d       = sck_q;
    ss_d        = ss_q;
    mosi_d      = mosi_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_SETUP;
          hdiv_d    = req_div;
          div_d     = req_div;
          nbits_d   = CNT_WIDTH'(req_len) + CNT_WIDTH'(1);
          bit_cnt_d = '0;
          tx_d      = req_data;
          rx_d      = '0;
          ss_d      = 1'b0;
          sck_d     = 1'b0;
          mosi_d    = req_data[DATA_WIDTH-1];
        end
      end

      ST_SETUP: begin
        if (div_zero) begin
          state_d = ST_XFER;
          div_d   = hdiv_q;
          sck_d   = 1'b1;
          if (!SAMPLE_ON_FALL) rx_d = rx_shifted;
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      ST_XFER: begin
        if (div_zero) begin
          div_d = hdiv_q;
          if (sck_q) begin
            // Falling edge: count the bit, then either finish or present the next one.
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (SAMPLE_ON_FALL) rx_d = rx_shifted;
            if (bit_cnt_d == nbits_q) begin
              state_d = ST_HOLD;
            end else begin
              tx_d   = tx_q << 1;
              mosi_d = tx_q[DATA_WIDTH-2];
            end
          end else begin
            sck_d = 1'b1;
            if (!SAMPLE_ON_FALL) rx_d = rx_shifted;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      ST_HOLD: begin
        if (div_zero) begin
          state_d     = ST_DONE;
          ss_d        = 1'b1;
          mosi_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        ss_d    = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      hdiv_q      <= '0;
      nbits_q     <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      sck_q       <= 1'b0;
      ss_q        <= 1'b1;
      mosi_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      hdiv_q      <= hdiv_d;
      nbits_q     <= nbits_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      sck_q       <= sck_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sck       = sck_q;
  assign ss        = ss_q;
  assign mosi      = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_master : randomized self-checking bench with a frame-level model. |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_spi_master;

  localparam int DW = 16;
  localparam int DV = 8;
  localparam int LW = $clog2(DW);

  logic          clock     = 1'b0;
  logic          resetn    = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_data  = '0;
  logic [LW-1:0] req_len   = '0;
  logic [DV-1:0] req_div   = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          sck;
  logic          ss;
  logic          mosi;
  logic          miso;

  logic          loopback = 1'b1;
  logic          slv_miso = 1'b0;
  assign miso = loopback ? mosi : slv_miso;

  spi_master #(.DATA_WIDTH(DW), .DIV_WIDTH(DV)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_len   (req_len),
    .req_div   (req_div),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .sck       (sck),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave model: mode 0 shifts out on sck falls; rise mode updates miso on sck rises.
  logic          slv_rise_mode = 1'b0;
  logic [DW-1:0] slv_word      = '0;
  int            slv_n         = DW;
  int            slv_idx       = 0;

  always @(negedge ss) begin
    slv_idx = 0;
    if (!slv_rise_mode) slv_miso = slv_word[slv_n-1];
    else                slv_miso = 1'b0;
  end

  always @(posedge sck) begin
    if (slv_rise_mode && slv_idx < slv_n) begin
      slv_miso = slv_word[slv_n-1-slv_idx];
      slv_idx++;
    end
  end

  always @(negedge sck) begin
    if (!slv_rise_mode && ss == 1'b0) begin
      slv_idx++;
      if (slv_idx < slv_n) slv_miso = slv_word[slv_n-1-slv_idx];
    end
  end

  // Bus monitor, sampled mid-cycle.
  int            ss_low_cnt = 0;
  int            rise_cnt   = 0;
  int            phase_err  = 0;
  int            ready_viol = 0;
  int            run_len    = 0;
  int            cur_h      = 1;
  int            ss_rise_cyc = 0;
  int            last_gap   = 0;
  logic          sck_prev   = 1'b0;
  logic          ss_prev    = 1'b1;
  logic          mosi_seq[$];
  logic [DW-1:0] rsp_q[$];
  int            rsp_cyc_q[$];
  int            acc_cyc[$];

  always @(negedge clock) begin
    if (!resetn) begin
      sck_prev = 1'b0;
      ss_prev  = 1'b1;
      run_len  = 0;
    end else begin
      if (req_valid && req_ready) acc_cyc.push_back(cyc);
      if (rsp_valid) begin
        rsp_q.push_back(rsp_data);
        rsp_cyc_q.push_back(cyc);
      end
      if (ss == 1'b0) begin
        ss_low_cnt++;
        if (ss_prev == 1'b1) last_gap = cyc - ss_rise_cyc;
        if (req_ready) ready_viol++;
        if (ss_prev == 1'b0 && sck != sck_prev) begin
          if (run_len != cur_h) phase_err++;
          run_len = 1;
        end else begin
          run_len++;
        end
        if (sck && !sck_prev) begin
          rise_cnt++;
          mosi_seq.push_back(mosi);
        end
      end else if (ss_prev == 1'b0) begin
        if (run_len != cur_h) phase_err++;
        run_len     = 0;
        ss_rise_cyc = cyc;
      end
      sck_prev = sck;
      ss_prev  = ss;
    end
  end

  task automatic clear_mon(input int div);
    ss_low_cnt = 0;
    rise_cnt   = 0;
    phase_err  = 0;
    ready_viol = 0;
    mosi_seq.delete();
    cur_h = div + 1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_sck"},       32'(sck),       32'd0);
    check_eq({tag, "_ss"},        32'(ss),        32'd1);
    check_eq({tag, "_mosi"},      32'(mosi),      32'd1);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  // One frame from idle; the model: ss low (2N+1)*H, N rises, all phases H,
  // mosi = top N bits of data, response = expected rx word.
  task automatic run_frame(input logic [DW-1:0] d, input int len, input int div,
                           input logic [31:0] exp_rx);
    int          n;
    int          budget;
    int          waited;
    logic [31:0] got_mosi;
    logic [31:0] exp_mosi;
    n      = len + 1;
    budget = (2 * n + 1) * (div + 1) + 20;
    clear_mon(div);
    rsp_q.delete();
    req_valid = 1'b1;
    req_data  = d;
    req_len   = LW'(len);
    req_div   = DV'(div);
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_data  = DW'($urandom);
    req_len   = LW'($urandom);
    req_div   = DV'($urandom);
    waited = 0;
    while (rsp_q.size() == 0 && waited < budget) begin
      @(posedge clock); #1;
      waited++;
    end
    check_eq("rsp_seen", 32'(rsp_q.size()), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    check_eq("rsp_single", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0) check_eq("rsp_data", 32'(rsp_q[0]), exp_rx);
    check_eq("ss_low_cycles", 32'(ss_low_cnt), 32'((2 * n + 1) * (div + 1)));
    check_eq("sck_rises", 32'(rise_cnt), 32'(n));
    check_eq("sck_phase_len", 32'(phase_err), 32'd0);
    check_eq("ready_in_frame", 32'(ready_viol), 32'd0);
    exp_mosi = 32'(d) >> (DW - n);
    got_mosi = '0;
    foreach (mosi_seq[i]) got_mosi = {got_mosi[30:0], mosi_seq[i]};
    check_eq("mosi_seq", got_mosi, exp_mosi);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [31:0]   exp;
    int            waited;
    int            len;
    int            div;

    // Reset held with random inputs.
    loopback = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'($urandom);
      req_data  = DW'($urandom);
      req_len   = LW'($urandom);
      req_div   = DV'($urandom);
      slv_miso  = 1'($urandom);
      @(posedge clock); #1;
      check_idle("reset");
      check_eq("reset_rsp_data", 32'(rsp_data), 32'd0);
    end
    req_valid = 1'b0;
    resetn    = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check_idle("post_reset");
    end

    // Loopback, full-width frame, fastest clock.
    loopback = 1'b1;
    run_frame(16'hA5C3, 15, 0, 32'hA5C3);

    // Short frame, slow clock, miso tied high.
    loopback      = 1'b0;
    slv_rise_mode = 1'b0;
    slv_word      = 16'hFFFF;
    slv_n         = 4;
    run_frame(16'h8000, 3, 2, 32'h000F);

    // Back-to-back with req_valid held high.
    loopback = 1'b1;
    clear_mon(1);
    acc_cyc.delete();
    rsp_cyc_q.delete();
    rsp_q.delete();
    a = DW'($urandom);
    b = DW'($urandom);
    req_valid = 1'b1;
    req_data  = a;
    req_len   = LW'(15);
    req_div   = DV'(1);
    @(posedge clock); #1;
    req_data = b;
    waited = 0;
    while (acc_cyc.size() < 2 && waited < 200) begin
      @(posedge clock); #1;
      waited++;
    end
    req_valid = 1'b0;
    while (rsp_q.size() < 2 && waited < 400) begin
      @(posedge clock); #1;
      waited++;
    end
    check_eq("b2b_rsp_count", 32'(rsp_q.size()), 32'd2);
    if (rsp_q.size() >= 2) begin
      check_eq("b2b_rsp0", 32'(rsp_q[0]), 32'(a));
      check_eq("b2b_rsp1", 32'(rsp_q[1]), 32'(b));
    end
    if (acc_cyc.size() >= 2 && rsp_cyc_q.size() >= 1)
      check_eq("b2b_accept_after_rsp", 32'(acc_cyc[1] - rsp_cyc_q[0]), 32'd1);
    check_eq("b2b_ss_gap_ge1", 32'(last_gap >= 1), 32'd1);
    repeat (2) @(posedge clock);
    #1;

    // Reset in the middle of a frame.
    loopback = 1'b1;
    clear_mon(1);
    rsp_q.delete();
    req_valid = 1'b1;
    req_data  = DW'($urandom);
    req_len   = LW'(15);
    req_div   = DV'(1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    waited = 0;
    while (rise_cnt < 5 && waited < 100) begin
      @(posedge clock); #1;
      waited++;
    end
    check_eq("midrst_rises", 32'(rise_cnt), 32'd5);
    resetn = 1'b0;
    #1;
    check_idle("midrst");
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (80) @(posedge clock);
    #1;
    check_eq("midrst_no_rsp", 32'(rsp_q.size()), 32'd0);
    a = DW'($urandom);
    run_frame(a, 15, 1, 32'(a));

    // Slave that changes miso on sck rising edges.
    loopback      = 1'b0;
    slv_rise_mode = 1'b1;
    slv_word      = 16'h003C;
    slv_n         = 8;
`ifdef SPI_MASTER_MISO_FALL_SAMPLE_EN
    exp = 32'h003C;
`else
    exp = 32'h001E;
`endif
    run_frame(DW'($urandom), 7, 1, exp);
    slv_rise_mode = 1'b0;

    // Single-bit frame at the slowest clock.
    loopback = 1'b1;
    a = DW'($urandom);
    run_frame(a, 0, 255, 32'(a) >> (DW - 1));

    // Randomized frames.
    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(0, DW - 1);
      div = $urandom_range(0, 6);
      a   = DW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        loopback = 1'b1;
        exp      = 32'(a) >> (DW - (len + 1));
      end else begin
        loopback = 1'b0;
        slv_word = DW'($urandom);
        slv_n    = len + 1;
        exp      = 32'(slv_word) & ((32'd1 << (len + 1)) - 32'd1);
      end
      run_frame(a, len, div, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
